// File: rtl/mux8to1_serializer_if.sv
// ---------------------------------------------------------------------------
// mux8to1_serializer_if
// Bundles the parallel-word handshake and the serial slot outputs of
// mux8to1_serializer. The master side supplies words and observes the serial
// stream; the slave side is the serializer itself.
// ---------------------------------------------------------------------------
interface mux8to1_serializer_if;
    logic [7:0] D;
    logic       in_valid;
    logic       in_ready;
    logic       O;
    logic [2:0] S;
    logic       o_valid;
    logic       frame_sync;
    logic       parity_slot;

    modport master (
        output D,
        output in_valid,
        input  in_ready,
        input  O,
        input  S,
        input  o_valid,
        input  frame_sync,
        input  parity_slot
    );

    modport slave (
        input  D,
        input  in_valid,
        output in_ready,
        output O,
        output S,
        output o_valid,
        output frame_sync,
        output parity_slot
    );
endinterface

// File: rtl/mux8to1_serializer.sv
// ---------------------------------------------------------------------------
// mux8to1_serializer
// Captures an 8-bit word on a valid/ready handshake and emits it one channel
// per cycle on O (channel D[n] in slot n), with S carrying the channel index
// for the far-end 1-to-8 demux. frame_sync marks slot 0. A new word can be
// accepted in the final slot so frames run back to back without a gap.
//
// Optional feature (macro MUX8_PARITY_EN): each frame gains a ninth slot after
// slot 7 carrying the even parity of the word, with S=7 and parity_slot=1.
// That parity slot then becomes the final slot of the frame. Without the
// macro, frames are 8 slots long and parity_slot is tied low.
// ---------------------------------------------------------------------------
module mux8to1_serializer #(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mux8to1_serializer_if.slave    bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t     state_r;
    logic [2:0] slot_r;
    logic [7:0] word_r;
    logic       o_r;
    logic [2:0] s_r;
    logic       o_valid_r;
    logic       frame_sync_r;
`ifdef MUX8_PARITY_EN
    logic       par_phase_r;
    logic       parity_slot_r;
`endif

    logic       final_slot_s;
    logic       in_ready_s;
    logic       take_s;
    logic [2:0] next_slot_s;

    // Even parity of a word: 1 when the word holds an odd number of ones.
    function automatic logic even_parity(input logic [7:0] w);
        return ^w;
    endfunction

    // Final-slot detection, ready generation and handshake qualification.
    always_comb begin
        final_slot_s = 1'b0;
        next_slot_s  = slot_r + 3'd1;
        if (state_r == SEND) begin
`ifdef MUX8_PARITY_EN
            final_slot_s = par_phase_r;
`else
            final_slot_s = (slot_r == 3'd7);
`endif
        end else begin
            final_slot_s = 1'b0;
        end
        in_ready_s = (state_r == IDLE) || final_slot_s;
        take_s     = in_ready_s && bus.in_valid;
    end

    // Frame sequencer: state, slot counter, holding register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            slot_r        <= 3'd0;
            word_r        <= 8'h00;
            o_r           <= IDLE_LEVEL;
            s_r           <= 3'd0;
            o_valid_r     <= 1'b0;
            frame_sync_r  <= 1'b0;
`ifdef MUX8_PARITY_EN
            par_phase_r   <= 1'b0;
            parity_slot_r <= 1'b0;
`endif
        end else if (take_s) begin
            // Handshake: capture the word and present slot 0 immediately.
            state_r       <= SEND;
            slot_r        <= 3'd0;
            word_r        <= bus.D;
            o_r           <= bus.D[0];
            s_r           <= 3'd0;
            o_valid_r     <= 1'b1;
            frame_sync_r  <= 1'b1;
`ifdef MUX8_PARITY_EN
            par_phase_r   <= 1'b0;
            parity_slot_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    state_r       <= IDLE;
                    slot_r        <= 3'd0;
                    o_r           <= IDLE_LEVEL;
                    s_r           <= 3'd0;
                    o_valid_r     <= 1'b0;
                    frame_sync_r  <= 1'b0;
`ifdef MUX8_PARITY_EN
                    par_phase_r   <= 1'b0;
                    parity_slot_r <= 1'b0;
`endif
                end
                SEND: begin
                    if (final_slot_s) begin
                        // Frame done and no new word offered: go quiet.
                        state_r       <= IDLE;
                        slot_r        <= 3'd0;
                        o_r           <= IDLE_LEVEL;
                        s_r           <= 3'd0;
                        o_valid_r     <= 1'b0;
                        frame_sync_r  <= 1'b0;
`ifdef MUX8_PARITY_EN
                        par_phase_r   <= 1'b0;
                        parity_slot_r <= 1'b0;
`endif
`ifdef MUX8_PARITY_EN
                    end else if (slot_r == 3'd7) begin
                        // Data slots exhausted: append the parity slot, S stays at 7.
                        state_r       <= SEND;
                        par_phase_r   <= 1'b1;
                        parity_slot_r <= 1'b1;
                        o_r           <= even_parity(word_r);
                        s_r           <= 3'd7;
                        o_valid_r     <= 1'b1;
                        frame_sync_r  <= 1'b0;
`endif
                    end else begin
                        state_r       <= SEND;
                        slot_r        <= next_slot_s;
                        o_r           <= word_r[next_slot_s];
                        s_r           <= next_slot_s;
                        o_valid_r     <= 1'b1;
                        frame_sync_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    slot_r        <= 3'd0;
                    o_r           <= IDLE_LEVEL;
                    s_r           <= 3'd0;
                    o_valid_r     <= 1'b0;
                    frame_sync_r  <= 1'b0;
`ifdef MUX8_PARITY_EN
                    par_phase_r   <= 1'b0;
                    parity_slot_r <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.O          = o_r;
    assign bus.S          = s_r;
    assign bus.o_valid    = o_valid_r;
    assign bus.frame_sync = frame_sync_r;
`ifdef MUX8_PARITY_EN
    assign bus.parity_slot = parity_slot_r;
`else
    assign bus.parity_slot = 1'b0;
`endif

endmodule

// File: tb/tb_mux8to1_serializer.sv
// ---------------------------------------------------------------------------
// tb_mux8to1_serializer
// Self-checking bench for mux8to1_serializer. Each accepted word pushes its
// expected slot records onto a scoreboard queue; a negedge monitor pops one
// record per live slot and checks idle outputs when the queue is empty.
// Table vectors carry hand-written serial sequences; the multi-cycle corner
// cases (back-to-back, mid-frame D change, reset mid-frame) are sequences.
// ---------------------------------------------------------------------------
module tb_mux8to1_serializer;

    localparam logic IDLE_LEVEL = 1'b0;
`ifdef MUX8_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FLEN = PAR ? 9 : 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    mux8to1_serializer_if bus ();

    mux8to1_serializer #(.IDLE_LEVEL(IDLE_LEVEL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       o;
        logic [2:0] s;
        logic       fs;
        logic       ps;
        logic       last;
    } slot_t;

    typedef struct {
        logic [7:0] d;
        logic [0:7] seq;   // expected O in slot order 0..7
        logic       par;   // expected O in the parity slot
    } vec_t;

    slot_t sb_q[$];
    int    n_cmp  = 0;
    int    n_bad  = 0;
    bit    mon_en = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [0:7] seq, input logic par);
        slot_t e;
        for (int n = 0; n < 8; n++) begin
            e.o    = seq[n];
            e.s    = n[2:0];
            e.fs   = (n == 0);
            e.ps   = 1'b0;
            e.last = (n == 7) && !PAR;
            sb_q.push_back(e);
        end
        if (PAR) begin
            e.o    = par;
            e.s    = 3'd7;
            e.fs   = 1'b0;
            e.ps   = 1'b1;
            e.last = 1'b1;
            sb_q.push_back(e);
        end
    endtask

    function automatic logic [0:7] model_seq(input logic [7:0] d);
        logic [0:7] s;
        for (int n = 0; n < 8; n++) s[n] = d[n];
        return s;
    endfunction

    // Offer a word and wait (bounded) for the handshake edge; returns edges waited.
    task automatic send(input logic [7:0] d, input logic [0:7] seq, input logic par,
                        output int waited);
        logic rdy;
        rdy          = 1'b0;
        waited       = 0;
        bus.D        = d;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            waited++;
            if (rdy) break;
        end
        if (rdy) begin
            push_frame(seq, par);
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL handshake_timeout: word %0h never accepted", d);
            waited = -1;
        end
        #1 bus.in_valid = 1'b0;
    endtask

    // Scoreboard monitor: one popped record per live slot, idle checks otherwise.
    always @(negedge clk) begin
        slot_t e;
        if (mon_en) begin
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("o_valid",     {7'd0, bus.o_valid},     8'd1);
                chk("O",           {7'd0, bus.O},           {7'd0, e.o});
                chk("S",           {5'd0, bus.S},           {5'd0, e.s});
                chk("frame_sync",  {7'd0, bus.frame_sync},  {7'd0, e.fs});
                chk("parity_slot", {7'd0, bus.parity_slot}, {7'd0, e.ps});
                chk("in_ready",    {7'd0, bus.in_ready},    {7'd0, e.last});
            end else begin
                chk("idle_o_valid",    {7'd0, bus.o_valid},     8'd0);
                chk("idle_O",          {7'd0, bus.O},           {7'd0, IDLE_LEVEL});
                chk("idle_S",          {5'd0, bus.S},           8'd0);
                chk("idle_frame_sync", {7'd0, bus.frame_sync},  8'd0);
                chk("idle_parity",     {7'd0, bus.parity_slot}, 8'd0);
                chk("idle_in_ready",   {7'd0, bus.in_ready},    8'd1);
            end
        end
    end

    vec_t tbl[6];
    int   w;

    initial begin
        tbl[0] = '{d: 8'hA5, seq: 8'b10100101, par: 1'b0};
        tbl[1] = '{d: 8'h07, seq: 8'b11100000, par: 1'b1};
        tbl[2] = '{d: 8'h03, seq: 8'b11000000, par: 1'b0};
        tbl[3] = '{d: 8'h12, seq: 8'b01001000, par: 1'b0};
        tbl[4] = '{d: 8'h80, seq: 8'b00000001, par: 1'b1};
        tbl[5] = '{d: 8'hF0, seq: 8'b00001111, par: 1'b0};

        bus.D        = 8'h00;
        bus.in_valid = 1'b0;

        // Asynchronous reset: outputs must settle before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_o_valid",    {7'd0, bus.o_valid},     8'd0);
        chk("rst_O",          {7'd0, bus.O},           {7'd0, IDLE_LEVEL});
        chk("rst_S",          {5'd0, bus.S},           8'd0);
        chk("rst_frame_sync", {7'd0, bus.frame_sync},  8'd0);
        chk("rst_parity",     {7'd0, bus.parity_slot}, 8'd0);
        chk("rst_in_ready",   {7'd0, bus.in_ready},    8'd1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;

        // Table vectors, each sent from idle.
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].d, tbl[i].seq, tbl[i].par, w);
            chk("idle_accept_edges", w[7:0], 8'd1);
            repeat (FLEN + 2) @(posedge clk);
            #1;
        end

        // Back-to-back: second word waits exactly one frame, no idle gap.
        send(8'h3C, model_seq(8'h3C), ^(8'h3C), w);
        send(8'hFF, model_seq(8'hFF), ^(8'hFF), w);
        chk("b2b_accept_edges", w[7:0], FLEN[7:0]);
        repeat (FLEN + 2) @(posedge clk);
        #1;

        // D changes to 00 mid-frame: current frame intact, 00 taken at final slot.
        send(8'h5A, model_seq(8'h5A), ^(8'h5A), w);
        send(8'h00, model_seq(8'h00), ^(8'h00), w);
        chk("midchg_accept_edges", w[7:0], FLEN[7:0]);
        repeat (FLEN + 2) @(posedge clk);
        #1;

        // Reset at slot 4 of F0: immediate reset values, then a fresh frame
        // (not slots 5-7) on the first edge after release.
        send(8'hF0, 8'b00001111, 1'b0, w);
        repeat (4) @(posedge clk);
        #2;
        chk("pre_rst_S", {5'd0, bus.S}, 8'd4);
        chk("pre_rst_O", {7'd0, bus.O}, 8'd1);
        mon_en       = 1'b0;
        bus.D        = 8'hC3;
        bus.in_valid = 1'b1;
        rst_n        = 1'b0;
        #1;
        chk("midrst_o_valid",    {7'd0, bus.o_valid},     8'd0);
        chk("midrst_O",          {7'd0, bus.O},           {7'd0, IDLE_LEVEL});
        chk("midrst_S",          {5'd0, bus.S},           8'd0);
        chk("midrst_frame_sync", {7'd0, bus.frame_sync},  8'd0);
        chk("midrst_parity",     {7'd0, bus.parity_slot}, 8'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        push_frame(model_seq(8'hC3), ^(8'hC3));
        #1 bus.in_valid = 1'b0;

        // Drain the scoreboard (bounded), then observe a few idle cycles.
        for (int t = 0; t < 40; t++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("sb_drained", sb_q.size() > 0 ? 8'd1 : 8'd0, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
